// File: rtl/lram_stream_reader.sv
// lram_stream_reader
// Read-side engine for a dual-port LUT RAM circular buffer. It compares the
// local read pointer with the writer's pointer, drives the RAM's asynchronous
// read address, and drains entries through a single registered valid/ready
// output stage. The read pointer goes back to the writer so the writer can
// detect when the buffer is full.
module lram_stream_reader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   i_wptr,
  output logic [ADDR_W:0]   o_rptr,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W:0]   o_level,
  output logic              o_err
);

  // DEPTH at pointer width, so the overrun compare needs no width extension.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W:0] rptr_q;
  logic [ADDR_W:0] avail;
  logic            fetch;
  logic            xfer;

  // Occupancy. Modulo subtraction on wrap-bit pointers gives 0..DEPTH for a
  // well-behaved writer. A value above DEPTH means the writer overran us.
  always_comb begin
    avail = i_wptr - rptr_q;
  end

  // Fetch whenever an entry is waiting and the output stage is empty or is
  // being emptied this cycle. i_ready reaches only this enable, so it has no
  // combinational path to o_valid or o_data.
  always_comb begin
    fetch = (avail != '0) && (!o_valid || i_ready) && !i_flush;
    xfer  = o_valid && i_ready;
  end

  // Read pointer and output stage. Flush takes priority and resynchronises to
  // the writer. A fetch reloads the stage even when a beat leaves in the same
  // cycle, which keeps the stream back-to-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (i_flush) begin
      rptr_q  <= i_wptr;
      o_valid <= 1'b0;
    end else if (fetch) begin
      rptr_q  <= rptr_q + 1'b1;
      o_data  <= i_rdata;
      o_valid <= 1'b1;
    end else if (xfer) begin
      o_valid <= 1'b0;
    end
  end

  // Sticky overrun flag. It only reports the overrun and does not steer the
  // datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_err <= 1'b0;
    end else if (avail > DEPTH_L) begin
      o_err <= 1'b1;
    end
  end

  // Exported pointer, RAM address (low bits, wrap bit dropped) and level.
  always_comb begin
    o_rptr  = rptr_q;
    o_raddr = rptr_q[ADDR_W-1:0];
    o_level = avail;
  end

endmodule
